// File: rtl/ycbcr_pkg.sv
// Shared definitions for the YCbCr 4:4:4 -> 4:2:2 -> 4:2:0 conversion stages.
package ycbcr_pkg;

    localparam int LAT = 2;

    typedef struct packed {
        logic       vsync;
        logic       href;
        logic       clken;
        logic [7:0] y;
        logic [7:0] c;
        logic       c_valid;
    } pix_stage_t;

    function automatic logic [7:0] avg_rnd8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b} + 9'd1;
        return sum[8:1];
    endfunction

endpackage

// File: rtl/image_ycbcr422_ycbcr420_if.sv
// Pixel-stream bundle around the 4:2:2 -> 4:2:0 stage: per_* upstream stream, post_* downstream stream.
interface image_ycbcr422_ycbcr420_if;

    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [15:0] per_img_YCbCr;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic [7:0]  post_img_Y;
    logic [7:0]  post_img_C;
    logic        post_c_valid;

    // master: stream source / sink around the converter; slave: the converter itself
    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_YCbCr,
        input  post_frame_vsync, post_frame_href, post_frame_clken,
        input  post_img_Y, post_img_C, post_c_valid
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_YCbCr,
        output post_frame_vsync, post_frame_href, post_frame_clken,
        output post_img_Y, post_img_C, post_c_valid
    );

endinterface

// File: rtl/line_buf_sdp.sv
// Simple dual-port line buffer: one write port, one registered read port, single clock.
module line_buf_sdp #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/image_ycbcr422_ycbcr420.sv
// 4:2:2 -> 4:2:0 vertical chroma decimation over line pairs; Y and syncs pass with LAT=2.
// YCBCR420_AVG_EN: average each pair through a line buffer; otherwise odd lines carry their own chroma.
module image_ycbcr422_ycbcr420
    import ycbcr_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int ADDR_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    image_ycbcr422_ycbcr420_if.slave  bus
);

    if ((1 << ADDR_W) < H_ACTIVE) begin : g_depth_chk
        $error("line buffer is shallower than H_ACTIVE");
    end
    if (LAT != 2) begin : g_lat_chk
        $error("datapath below is exactly two register stages");
    end

    logic       vsync_prev_q, href_prev_q;
    logic       line_odd_q, line_odd_d;
    logic       abort_q, abort_d;
    logic       accept, vs_rise, href_fall;
    pix_stage_t s1_q, s1_d, s2_q, s2_d;

    always_comb begin
        accept     = bus.per_frame_href & bus.per_frame_clken;
        vs_rise    = bus.per_frame_vsync & ~vsync_prev_q;
        href_fall  = ~bus.per_frame_href & href_prev_q;
        line_odd_d = line_odd_q;
        abort_d    = abort_q;
        if (vs_rise) begin
            line_odd_d = 1'b0;
            // a line cut short by vsync must not advance the new frame past line 0
            abort_d    = bus.per_frame_href;
        end else if (href_fall) begin
            line_odd_d = abort_q ? 1'b0 : ~line_odd_q;
            abort_d    = 1'b0;
        end
        s1_d.vsync   = bus.per_frame_vsync;
        s1_d.href    = bus.per_frame_href;
        s1_d.clken   = bus.per_frame_clken;
        s1_d.y       = bus.per_img_YCbCr[7:0];
        s1_d.c       = bus.per_img_YCbCr[15:8];
        s1_d.c_valid = accept & line_odd_q;
    end

`ifdef YCBCR420_AVG_EN
    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_ACTIVE);

    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic             use_avg_q, use_avg_d;
    logic             in_range, buf_we;
    logic [7:0]       buf_rdata;

    always_comb begin
        in_range  = pix_cnt_q < H_MAX;
        buf_we    = accept & ~line_odd_q & in_range;
        use_avg_d = in_range;
        pix_cnt_d = pix_cnt_q;
        if (vs_rise || href_fall) begin
            pix_cnt_d = '0;
        end else if (accept && in_range) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end
    end

    line_buf_sdp #(.ADDR_W(ADDR_W)) u_line_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (pix_cnt_q[ADDR_W-1:0]),
        .wdata_i (bus.per_img_YCbCr[15:8]),
        .raddr_i (pix_cnt_q[ADDR_W-1:0]),
        .rdata_o (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt_q <= '0;
            use_avg_q <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            use_avg_q <= use_avg_d;
        end
    end

    always_comb begin
        s2_d   = s1_q;
        s2_d.c = 8'h00;
        if (s1_q.c_valid) begin
            s2_d.c = use_avg_q ? avg_rnd8(buf_rdata, s1_q.c) : s1_q.c;
        end
    end
`else
    always_comb begin
        s2_d = s1_q;
        if (!s1_q.c_valid) begin
            s2_d.c = 8'h00;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            line_odd_q   <= 1'b0;
            abort_q      <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
        end else begin
            vsync_prev_q <= bus.per_frame_vsync;
            href_prev_q  <= bus.per_frame_href;
            line_odd_q   <= line_odd_d;
            abort_q      <= abort_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
        end
    end

    assign bus.post_frame_vsync = s2_q.vsync;
    assign bus.post_frame_href  = s2_q.href;
    assign bus.post_frame_clken = s2_q.clken;
    assign bus.post_img_Y       = s2_q.y;
    assign bus.post_img_C       = s2_q.c;
    assign bus.post_c_valid     = s2_q.c_valid;

endmodule

// File: tb/tb_image_ycbcr422_ycbcr420.sv
// Directed self-checking bench for image_ycbcr422_ycbcr420; expectations follow YCBCR420_AVG_EN.
module tb_image_ycbcr422_ycbcr420;
    import ycbcr_pkg::*;

`ifdef YCBCR420_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] line_c [1024];
    logic [7:0] obs_y  [1024];
    logic [7:0] obs_c  [1024];
    logic       obs_v  [1024];
    logic [1:0] obs_hc [1024];
    logic [2:0] obs_vs;

    always #5 clk = ~clk;

    image_ycbcr422_ycbcr420_if bus_if ();

    image_ycbcr422_ycbcr420 #(.H_ACTIVE(640), .ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    function automatic logic [7:0] exp_c(input logic [7:0] even_c, input logic [7:0] odd_c,
                                         input logic in_rng);
        logic [8:0] s;
        s = {1'b0, even_c} + {1'b0, odd_c} + 9'd1;
        if (AVG_EN && in_rng) return s[8:1];
        return odd_c;
    endfunction

    task automatic tick(input logic v, input logic h, input logic ce, input logic [15:0] d);
        bus_if.per_frame_vsync = v;
        bus_if.per_frame_href  = h;
        bus_if.per_frame_clken = ce;
        bus_if.per_img_YCbCr   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int idx);
        obs_y[idx]  = bus_if.post_img_Y;
        obs_c[idx]  = bus_if.post_img_C;
        obs_v[idx]  = bus_if.post_c_valid;
        obs_hc[idx] = {bus_if.post_frame_href, bus_if.post_frame_clken};
    endtask

    task automatic send_line(input int n, input logic [7:0] y_seed);
        for (int t = 0; t < n + LAT - 1; t++) begin
            if (t < n) tick(1'b0, 1'b1, 1'b1, {line_c[t], y_seed + 8'(t)});
            else       tick(1'b0, 1'b0, 1'b0, 16'h0000);
            if (t >= LAT - 1) capture(t - (LAT - 1));
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic send_vsync();
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        obs_vs[0] = bus_if.post_frame_vsync;
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        obs_vs[1] = bus_if.post_frame_vsync;
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        obs_vs[2] = bus_if.post_frame_vsync;
    endtask

    task automatic test_reset();
        logic [19:0] outs;
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
            outs = {bus_if.post_frame_vsync, bus_if.post_frame_href, bus_if.post_frame_clken,
                    bus_if.post_img_Y, bus_if.post_img_C, bus_if.post_c_valid};
            checks++;
            if (outs !== 20'h0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %h want 00000", i, outs);
            end
        end
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_basic();
        logic [7:0] lc [4];
        logic [7:0] ec [4];
        lc = '{8'h40, 8'h41, 8'h10, 8'h20};
        ec = '{8'h00, 8'h41, 8'h00, (AVG_EN ? 8'h18 : 8'h20)};
        send_vsync();
        checks++;
        if (obs_vs !== 3'b010) begin
            errors++;
            $display("FAIL basic_vsync_latency got %b want 010", obs_vs);
        end
        for (int ln = 0; ln < 4; ln++) begin
            for (int i = 0; i < 4; i++) line_c[i] = lc[ln];
            send_line(4, 8'(ln * 16));
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_y[i] !== 8'(ln * 16 + i) || obs_hc[i] !== 2'b11) begin
                    errors++;
                    $display("FAIL basic_y line %0d px %0d got y=%h hc=%b want y=%h hc=11",
                             ln, i, obs_y[i], obs_hc[i], 8'(ln * 16 + i));
                end
                checks++;
                if (obs_v[i] !== ln[0] || obs_c[i] !== ec[ln]) begin
                    errors++;
                    $display("FAIL basic_c line %0d px %0d got v=%b c=%h want v=%b c=%h",
                             ln, i, obs_v[i], obs_c[i], ln[0], ec[ln]);
                end
            end
        end
    endtask

    task automatic test_rounding();
        logic [7:0] ev_t [3][4];
        logic [7:0] od_t [3][4];
        logic [7:0] av_t [3][4];
        logic [7:0] want;
        ev_t = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h10, 8'h80, 8'hFE, 8'h00}};
        od_t = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'h01, 8'h01, 8'h01, 8'h01}, '{8'h20, 8'h81, 8'h01, 8'hFF}};
        av_t = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'h01, 8'h01, 8'h01, 8'h01}, '{8'h18, 8'h81, 8'h80, 8'h80}};
        send_vsync();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) line_c[i] = ev_t[p][i];
            send_line(4, 8'h80);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_v[i] !== 1'b0 || obs_c[i] !== 8'h00) begin
                    errors++;
                    $display("FAIL round_even pair %0d px %0d got v=%b c=%h want v=0 c=00",
                             p, i, obs_v[i], obs_c[i]);
                end
            end
            for (int i = 0; i < 4; i++) line_c[i] = od_t[p][i];
            send_line(4, 8'h90);
            for (int i = 0; i < 4; i++) begin
                want = AVG_EN ? av_t[p][i] : od_t[p][i];
                checks++;
                if (obs_v[i] !== 1'b1 || obs_c[i] !== want) begin
                    errors++;
                    $display("FAIL round_odd pair %0d px %0d got v=%b c=%h want v=1 c=%h",
                             p, i, obs_v[i], obs_c[i], want);
                end
            end
        end
    endtask

    task automatic test_long_line();
        logic [7:0] want;
        logic [7:0] ev;
        send_vsync();
        for (int i = 0; i < 700; i++) line_c[i] = (i < 640) ? 8'(i) : 8'hEE;
        send_line(700, 8'h00);
        for (int i = 0; i < 700; i++) begin
            checks++;
            if (obs_v[i] !== 1'b0 || obs_y[i] !== 8'(i)) begin
                errors++;
                $display("FAIL long_even px %0d got v=%b y=%h want v=0 y=%h", i, obs_v[i], obs_y[i], 8'(i));
            end
        end
        for (int i = 0; i < 700; i++) line_c[i] = 8'(i + 85);
        send_line(700, 8'h33);
        for (int i = 0; i < 700; i++) begin
            ev   = (i < 640) ? 8'(i) : 8'hEE;
            want = exp_c(ev, 8'(i + 85), i < 640);
            checks++;
            if (obs_v[i] !== 1'b1 || obs_c[i] !== want || obs_y[i] !== 8'(8'h33 + i)) begin
                errors++;
                $display("FAIL long_odd px %0d got v=%b c=%h y=%h want v=1 c=%h y=%h",
                         i, obs_v[i], obs_c[i], obs_y[i], want, 8'(8'h33 + i));
            end
        end
        checks++;
        if (obs_c[0] !== (AVG_EN ? 8'h2B : 8'h55) || obs_c[639] !== (AVG_EN ? 8'hAA : 8'hD4)) begin
            errors++;
            $display("FAIL long_edge_avg got c0=%h c639=%h", obs_c[0], obs_c[639]);
        end
        checks++;
        if (obs_c[640] !== 8'hD5 || obs_c[699] !== 8'h10) begin
            errors++;
            $display("FAIL long_raw got c640=%h c699=%h want D5 10", obs_c[640], obs_c[699]);
        end
        for (int i = 0; i < 4; i++) line_c[i] = 8'h22;
        send_line(4, 8'h00);
        for (int i = 0; i < 4; i++) line_c[i] = 8'h44;
        send_line(4, 8'h00);
        for (int i = 0; i < 4; i++) begin
            want = AVG_EN ? 8'h33 : 8'h44;
            checks++;
            if (obs_v[i] !== 1'b1 || obs_c[i] !== want) begin
                errors++;
                $display("FAIL long_next_pair px %0d got v=%b c=%h want v=1 c=%h", i, obs_v[i], obs_c[i], want);
            end
        end
    endtask

    task automatic test_vsync_abort();
        logic [7:0] want;
        send_vsync();
        for (int i = 0; i < 4; i++) line_c[i] = 8'h30;
        send_line(4, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 16'h50A0);
        tick(1'b0, 1'b1, 1'b1, 16'h50A1);
        capture(0);
        tick(1'b1, 1'b1, 1'b0, 16'h0000);
        capture(1);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        want = AVG_EN ? 8'h40 : 8'h50;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_v[i] !== 1'b1 || obs_c[i] !== want || obs_y[i] !== 8'(8'hA0 + i)) begin
                errors++;
                $display("FAIL abort_partial px %0d got v=%b c=%h y=%h want v=1 c=%h",
                         i, obs_v[i], obs_c[i], obs_y[i], want);
            end
        end
        for (int i = 0; i < 4; i++) line_c[i] = 8'h60;
        send_line(4, 8'h00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_v[i] !== 1'b0 || obs_c[i] !== 8'h00) begin
                errors++;
                $display("FAIL abort_restart_line0 px %0d got v=%b c=%h want v=0 c=00", i, obs_v[i], obs_c[i]);
            end
        end
        for (int i = 0; i < 4; i++) line_c[i] = 8'h70;
        send_line(4, 8'h00);
        want = AVG_EN ? 8'h68 : 8'h70;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_v[i] !== 1'b1 || obs_c[i] !== want) begin
                errors++;
                $display("FAIL abort_line1 px %0d got v=%b c=%h want v=1 c=%h", i, obs_v[i], obs_c[i], want);
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [19:0] outs;
        logic [7:0]  want;
        send_vsync();
        for (int i = 0; i < 4; i++) line_c[i] = 8'h10;
        send_line(4, 8'h00);
        tick(1'b0, 1'b1, 1'b1, 16'h3001);
        tick(1'b0, 1'b1, 1'b1, 16'h3002);
        rst_n = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 16'h3003);
        outs = {bus_if.post_frame_vsync, bus_if.post_frame_href, bus_if.post_frame_clken,
                bus_if.post_img_Y, bus_if.post_img_C, bus_if.post_c_valid};
        checks++;
        if (outs !== 20'h0) begin
            errors++;
            $display("FAIL midline_reset got %h want 00000", outs);
        end
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        outs = {bus_if.post_frame_vsync, bus_if.post_frame_href, bus_if.post_frame_clken,
                bus_if.post_img_Y, bus_if.post_img_C, bus_if.post_c_valid};
        checks++;
        if (outs !== 20'h0) begin
            errors++;
            $display("FAIL midline_after_release got %h want 00000", outs);
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        send_vsync();
        for (int i = 0; i < 4; i++) line_c[i] = 8'h10;
        send_line(4, 8'h00);
        for (int i = 0; i < 4; i++) line_c[i] = 8'h30;
        send_line(4, 8'h00);
        want = AVG_EN ? 8'h20 : 8'h30;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_v[i] !== 1'b1 || obs_c[i] !== want) begin
                errors++;
                $display("FAIL midline_resume px %0d got v=%b c=%h want v=1 c=%h", i, obs_v[i], obs_c[i], want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_long_line();
        test_vsync_abort();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
